matmul_sequencer: RTL and testbench

- Control FSM for the vector x matrix multiply datapath.
- Walks the M1 (1 x N_K vector) and M2 (N_K x N_COL matrix, column-major) address spaces in lockstep.
- Aligns multiply-accumulate enables with the memory read latency and writes one result per column.
- Replaces the free-running address generator with a start/busy/done-controlled, stallable sequencer that the top-level controller drives.

---
 rtl/matmul_pkg.sv | 32 +++
 rtl/matmul_sequencer_tag_pipe.sv | 48 ++++
 rtl/matmul_sequencer.sv | 154 +++++++++++++++
 tb/tb_matmul_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the vector x matrix multiply sequencer.
//   - Default dimensions and memory read latency.
//   - Derived address widths.
//   - Sequencer state encoding.
//   - Tag carried alongside each read through the memory-latency pipe.
package matmul_pkg;

   localparam int N_K     = 8;   // inner dimension, M1 depth, M2 words per column
   localparam int N_COL   = 16;  // output columns
   localparam int MEM_LAT = 1;   // M1/M2 read latency, 1..4

   localparam int K_W     = $clog2(N_K);
   localparam int COL_W   = $clog2(N_COL);
   localparam int ADDR2_W = $clog2(N_K * N_COL);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   // One tag per issued read. It travels with the read so that the datapath
   // strobes line up with the data returning from memory.
   typedef struct packed {
      logic             valid;  // a read was issued in this slot
      logic             first;  // k == 0: load the product instead of accumulating
      logic             last;   // k == N_K-1: column complete after this product
      logic [COL_W-1:0] col;    // column the product belongs to
   } tag_t;

endpackage

// File: rtl/matmul_sequencer_tag_pipe.sv
// mm_tag_pipe: DEPTH-stage shift register of tags matching the memory read
// latency. Shifts only when en is high, so a stall freezes the tags in place.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high clear of every stage
//   en    - shift enable (low while the sequencer is stalled)
//   d     - tag for the read issued this cycle
//   q     - tag whose read data is valid this cycle
//   empty - no valid tag anywhere in the pipe
module mm_tag_pipe
   import matmul_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  tag_t d,
   output tag_t q,
   output logic empty
);

   tag_t stage [DEPTH];

   // NOTE: every stage is cleared on reset because the valid bits are control
   // state; a stale valid would raise mac_en or res_we after a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
         // NOTE: non-blocking assignments give a true shift; blocking ones
         // would ripple d through every stage in a single edge.
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

   always_comb begin
      // NOTE: default before the loop, otherwise empty would be a latch.
      empty = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (stage[i].valid) empty = 1'b0;
      end
   end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: start/busy/done controlled, stallable address and
// strobe sequencer for the vector x matrix multiply datapath.
// Walks M1 (k) and M2 (col*N_K + k, column-major) in lockstep, aligns the
// MAC strobes with the memory read latency and writes one result per column.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset, overrides start and hold
//   start    - begin a multiply; honoured only in IDLE
//   hold     - stall; freezes counters, tag pipe and result stage
//   busy     - first issue cycle through the done cycle
//   done     - single-cycle pulse once the last result is written
//   rd_en    - read strobe for M1 and M2
//   Dir_M1   - M1 address (k)
//   Dir_M2   - M2 address (col*N_K + k)
//   mac_en   - datapath accumulates the current product
//   mac_clr  - with mac_en: load the product instead of accumulating
//   res_we   - result memory write strobe
//   res_addr - result address (column)
module matmul_sequencer #(
   parameter int N_K     = matmul_pkg::N_K,
   parameter int N_COL   = matmul_pkg::N_COL,
   parameter int MEM_LAT = matmul_pkg::MEM_LAT
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           hold,
   output logic                           busy,
   output logic                           done,
   output logic                           rd_en,
   output logic [$clog2(N_K)-1:0]         Dir_M1,
   output logic [$clog2(N_K*N_COL)-1:0]   Dir_M2,
   output logic                           mac_en,
   output logic                           mac_clr,
   output logic                           res_we,
   output logic [$clog2(N_COL)-1:0]       res_addr
);

   import matmul_pkg::*;

   localparam int KW = $clog2(N_K);
   localparam int CW = $clog2(N_COL);
   localparam int AW = $clog2(N_K * N_COL);

   localparam logic [KW-1:0] K_LAST   = KW'(N_K - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(N_COL - 1);

   state_t        state;
   logic [KW-1:0] k;
   logic [CW-1:0] col;
   logic [AW-1:0] addr2;
   logic          res_v;
   logic [CW-1:0] res_col;

   logic stall;
   logic issue;
   logic last_issue;
   logic final_write;
   logic pipe_empty;
   tag_t tag_in;
   tag_t tag_out;

   always_comb begin
      // hold only has an effect while work is in flight.
      stall       = hold && (state == ISSUE || state == DRAIN);
      issue       = (state == ISSUE) && !hold;
      last_issue  = issue && (k == K_LAST) && (col == COL_LAST);
      // Last column written and nothing left in flight.
      final_write = (state == DRAIN) && !stall && res_v &&
                    (res_col == COL_LAST) && pipe_empty;

      tag_in       = '0;
      tag_in.valid = issue;
      tag_in.first = (k == '0);
      tag_in.last  = (k == K_LAST);
      tag_in.col   = COL_W'(col);
   end

   mm_tag_pipe #(
      .DEPTH (MEM_LAT)
   ) u_tag_pipe (
      .clk   (clk),
      .rst   (rst),
      .en    (!stall),
      .d     (tag_in),
      .q     (tag_out),
      .empty (pipe_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         k       <= '0;
         col     <= '0;
         addr2   <= '0;
         res_v   <= 1'b0;
         res_col <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ISSUE;
                  k     <= '0;
                  col   <= '0;
                  addr2 <= '0;
               end
            end
            ISSUE: begin
               if (last_issue) begin
                  // Counters stay on the final address so Dir_M1/Dir_M2
                  // keep their last value until the next start.
                  state <= DRAIN;
               end else if (issue) begin
                  addr2 <= addr2 + AW'(1);
                  // Explicit wrap: N_K need not be a power of two.
                  if (k == K_LAST) begin
                     k   <= '0;
                     col <= col + CW'(1);
                  end else begin
                     k <= k + KW'(1);
                  end
               end
            end
            DRAIN: begin
               if (final_write) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // Result stage: one write the cycle after the last product of a column.
         if (!stall) begin
            res_v   <= tag_out.valid && tag_out.last;
            res_col <= CW'(tag_out.col);
         end
      end
   end

   // Strobes are gated by hold in the same cycle; addresses simply hold.
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign rd_en    = issue;
   assign Dir_M1   = k;
   assign Dir_M2   = addr2;
   assign mac_en   = tag_out.valid && !stall;
   assign mac_clr  = tag_out.valid && tag_out.first && !stall;
   assign res_we   = res_v && !stall;
   assign res_addr = res_col;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer. Two instances run side by side
// on the same stimulus: MEM_LAT=1 (defaults) and MEM_LAT=3.
// The reference model tracks each run as "progress" p, the number of
// non-stalled busy cycles since the first issue cycle, and derives every
// expected output from p with plain arithmetic.
module tb_matmul_sequencer;

   localparam int NK    = 8;
   localparam int NC    = 16;
   localparam int TOTAL = NK * NC;

   logic clk = 1'b0;
   logic rst, start, hold;

   logic       busy_o [2];
   logic       done_o [2];
   logic       rd_o   [2];
   logic [2:0] m1_o   [2];
   logic [6:0] m2_o   [2];
   logic       mac_o  [2];
   logic       clr_o  [2];
   logic       we_o   [2];
   logic [3:0] ra_o   [2];

   int checks = 0;
   int errors = 0;

   bit running  [2];
   int p        [2];
   int idle_idx [2];
   int rd_cnt   [2];
   int res_cnt  [2];
   int done_cnt [2];
   int done_cyc [2];
   int cyc;

   always #5 clk = ~clk;

   matmul_sequencer #(.MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .busy(busy_o[0]), .done(done_o[0]), .rd_en(rd_o[0]),
      .Dir_M1(m1_o[0]), .Dir_M2(m2_o[0]),
      .mac_en(mac_o[0]), .mac_clr(clr_o[0]),
      .res_we(we_o[0]), .res_addr(ra_o[0])
   );

   matmul_sequencer #(.MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .busy(busy_o[1]), .done(done_o[1]), .rd_en(rd_o[1]),
      .Dir_M1(m1_o[1]), .Dir_M2(m2_o[1]),
      .mac_en(mac_o[1]), .mac_clr(clr_o[1]),
      .res_we(we_o[1]), .res_addr(ra_o[1])
   );

   function automatic int lat(int m);
      return (m == 0) ? 1 : 3;
   endfunction

   task automatic check(input string tag, input int m,
                        input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s (MEM_LAT=%0d) cycle %0d: observed %0h expected %0h",
                tag, lat(m), cyc, got, exp);
      end
   endtask

   task automatic clear_counts();
      for (int m = 0; m < 2; m++) begin
         rd_cnt[m]   = 0;
         res_cnt[m]  = 0;
         done_cnt[m] = 0;
         done_cyc[m] = -1;
      end
   endtask

   // One clock cycle: drive inputs, compare at the falling edge, advance model.
   task automatic step(input logic s, input logic h, input logic r, input bit chk);
      start = s;
      hold  = h;
      rst   = r;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         int  L, q, idx;
         bit  e_done, stl, e_rd, e_mac, e_clr, e_we;
         L      = lat(m);
         e_done = running[m] && (p[m] == TOTAL + L + 1);
         stl    = running[m] && h && !e_done;
         idx    = running[m] ? ((p[m] < TOTAL) ? p[m] : TOTAL - 1) : idle_idx[m];
         e_rd   = running[m] && !stl && (p[m] < TOTAL);
         e_mac  = running[m] && !stl && (p[m] >= L) && (p[m] < TOTAL + L);
         e_clr  = e_mac && ((p[m] - L) % NK == 0);
         q      = p[m] - L - 1;
         e_we   = running[m] && !stl && (q >= 0) && (q < TOTAL) && (q % NK == NK - 1);
         if (chk) begin
            check("busy",    m, 32'(busy_o[m]), 32'(running[m]));
            check("done",    m, 32'(done_o[m]), 32'(e_done));
            check("rd_en",   m, 32'(rd_o[m]),   32'(e_rd));
            check("Dir_M1",  m, 32'(m1_o[m]),   32'(idx % NK));
            check("Dir_M2",  m, 32'(m2_o[m]),   32'(idx));
            check("mac_en",  m, 32'(mac_o[m]),  32'(e_mac));
            check("mac_clr", m, 32'(clr_o[m]),  32'(e_clr));
            check("res_we",  m, 32'(we_o[m]),   32'(e_we));
            if (e_we) check("res_addr", m, 32'(ra_o[m]), 32'(q / NK));
            if (rd_o[m] === 1'b1) rd_cnt[m]++;
            if (we_o[m] === 1'b1) res_cnt[m]++;
            if (done_o[m] === 1'b1) begin
               done_cnt[m]++;
               done_cyc[m] = cyc;
            end
         end
         if (r) begin
            running[m]  = 1'b0;
            p[m]        = 0;
            idle_idx[m] = 0;
         end else if (running[m]) begin
            if (e_done) begin
               running[m]  = 1'b0;
               idle_idx[m] = TOTAL - 1;
            end else if (!stl) begin
               p[m]++;
            end
         end else if (s) begin
            running[m] = 1'b1;
            p[m]       = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      start = 1'b0;
      hold  = 1'b0;
      rst   = 1'b1;
      cyc   = 0;
      for (int m = 0; m < 2; m++) begin
         running[m]  = 1'b0;
         p[m]        = 0;
         idle_idx[m] = 0;
      end
      clear_counts();

      // Reset for two cycles, then idle with start/hold low.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

      // Full run, start pulse at c0.
      clear_counts();
      cyc = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 140; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      check("done_cycle", 0, 32'(done_cyc[0]), 32'd131);
      check("done_cycle", 1, 32'(done_cyc[1]), 32'd133);
      for (int m = 0; m < 2; m++) begin
         check("rd_count",   m, 32'(rd_cnt[m]),   32'd128);
         check("res_count",  m, 32'(res_cnt[m]),  32'd16);
         check("done_count", m, 32'(done_cnt[m]), 32'd1);
      end

      // hold c20..c24, start re-asserted at c50 and at the MEM_LAT=1 done cycle.
      clear_counts();
      cyc = 0;
      for (int c = 0; c <= 145; c++) begin
         step(1'b0 | (c == 0) | (c == 50) | (c == 136),
              1'b0 | ((c >= 20) && (c <= 24)), 1'b0, 1'b1);
      end
      check("done_cycle_hold", 0, 32'(done_cyc[0]), 32'd136);
      check("done_cycle_hold", 1, 32'(done_cyc[1]), 32'd138);
      for (int m = 0; m < 2; m++) begin
         check("done_count_hold", m, 32'(done_cnt[m]), 32'd1);
         check("res_count_hold",  m, 32'(res_cnt[m]),  32'd16);
      end

      // Next start from IDLE runs normally.
      clear_counts();
      cyc = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 140; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      check("done_cycle_rerun", 0, 32'(done_cyc[0]), 32'd131);
      check("done_cycle_rerun", 1, 32'(done_cyc[1]), 32'd133);

      // Random starts and holds, checked cycle by cycle against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'b0 | ($urandom_range(0, 19) == 0),
              1'b0 | ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
      end
      step(1'b0, 1'b1, 1'b1, 1'b1);

      // Reset at c60 aborts the run.
      clear_counts();
      cyc = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int c = 1; c <= 75; c++) step(1'b0, 1'b0, 1'b0 | (c == 60), 1'b1);
      for (int m = 0; m < 2; m++) begin
         check("done_count_abort", m, 32'(done_cnt[m]), 32'd0);
      end

      // Clean run after the abort, with random holds.
      clear_counts();
      cyc = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int c = 1; c <= 320; c++) begin
         step(1'b0, 1'b0 | ($urandom_range(0, 4) == 0), 1'b0, 1'b1);
      end
      for (int m = 0; m < 2; m++) begin
         check("rd_count_after_abort",   m, 32'(rd_cnt[m]),   32'd128);
         check("res_count_after_abort",  m, 32'(res_cnt[m]),  32'd16);
         check("done_count_after_abort", m, 32'(done_cnt[m]), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
